// File: rtl/fifo_pkg.sv
// Shared async FIFO definitions used by both the read and write clock domains.
// Optional read-level outputs in r_clk_module are enabled by defining R_LEVEL_EN.
package fifo_pkg;

    localparam int FIFO_ADDRESS_SIZE = 4;
    localparam int FIFO_MEMORY_DEPTH = 16;

    function automatic int ptr_width(input int address_size);
        return address_size + 1;
    endfunction

    function automatic bit depth_matches(input int memory_depth, input int address_size);
        return memory_depth == (1 << address_size);
    endfunction

    // Memory address msb is the binary count bit ADDRESS_SIZE-1, recovered from the Gray pointer.
    function automatic logic addr_msb(input logic [31:0] gray, input int address_size);
        return gray[address_size] ^ gray[address_size-1];
    endfunction

endpackage

// File: rtl/binary_to_gray.sv
// Combinational binary to Gray-code converter.
module binary_to_gray #(
    parameter int SIZE = 5
) (
    input  logic [SIZE-1:0] bin,
    output logic [SIZE-1:0] gray
);

    assign gray = bin ^ (bin >> 1);

endmodule

// File: rtl/d_ff_async.sv
// Register bank with asynchronous active-high reset to a configurable value.
module d_ff_async #(
    parameter int              SIZE        = 1,
    parameter logic [SIZE-1:0] RESET_VALUE = '0
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [SIZE-1:0] d,
    output logic [SIZE-1:0] q
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q <= RESET_VALUE;
        end else begin
            q <= d;
        end
    end

endmodule

// File: rtl/gray_to_binary.sv
// Combinational Gray-code to binary converter.
module gray_to_binary #(
    parameter int SIZE = 5
) (
    input  logic [SIZE-1:0] gray,
    output logic [SIZE-1:0] bin
);

    for (genvar i = 0; i < SIZE; i++) begin : g_bit
        assign bin[i] = ^(gray >> i);
    end

endmodule

// File: rtl/r_level_calc.sv
// Registered read-side fill level and almost-empty flag from the synchronized write pointer.
import fifo_pkg::*;

module r_level_calc #(
    parameter int ADDRESS_SIZE        = FIFO_ADDRESS_SIZE,
    parameter int ALMOST_EMPTY_THRESH = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [ADDRESS_SIZE:0] w_gray_sync,
    input  logic [ADDRESS_SIZE:0] r_bnext,
    output logic [ADDRESS_SIZE:0] r_level,
    output logic                  r_almost_empty
);

    localparam int PTR_W = ptr_width(ADDRESS_SIZE);
    localparam logic [PTR_W-1:0] THRESH = PTR_W'(ALMOST_EMPTY_THRESH);

    logic [PTR_W-1:0] w_bin_sync;
    logic [PTR_W-1:0] level_next;

    gray_to_binary #(.SIZE(PTR_W)) u_w_g2b (
        .gray (w_gray_sync),
        .bin  (w_bin_sync)
    );

    // Modulo subtraction gives the correct count across pointer wrap.
    assign level_next = w_bin_sync - r_bnext;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_level        <= '0;
            r_almost_empty <= 1'b1;
        end else begin
            r_level        <= level_next;
            r_almost_empty <= (level_next <= THRESH);
        end
    end

endmodule

// File: rtl/two_ff_synchronizer.sv
// Two-stage synchronizer for a Gray-coded bus crossing into the clk domain.
module two_ff_synchronizer #(
    parameter int SIZE = 5
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [SIZE-1:0] d,
    output logic [SIZE-1:0] q
);

    logic [SIZE-1:0] stage1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stage1 <= '0;
            q      <= '0;
        end else begin
            stage1 <= d;
            q      <= stage1;
        end
    end

endmodule

// File: rtl/r_clk_module.sv
// Read-clock-domain half of the async FIFO: Gray read pointer, read address and empty flag.
// Define R_LEVEL_EN to add the r_level and r_almost_empty outputs.
import fifo_pkg::*;

module r_clk_module #(
    parameter int MEMORY_DEPTH        = FIFO_MEMORY_DEPTH,
    parameter int ADDRESS_SIZE        = FIFO_ADDRESS_SIZE,
    parameter int ALMOST_EMPTY_THRESH = 2
) (
    input  logic                    r_clk,
    input  logic                    r_rst,
    input  logic                    r_en,
    input  logic [ADDRESS_SIZE:0]   w_ptr,
    output logic [ADDRESS_SIZE:0]   r_ptr,
    output logic [ADDRESS_SIZE-1:0] r_addr,
    output logic                    r_empty
`ifdef R_LEVEL_EN
    ,
    output logic [ADDRESS_SIZE:0]   r_level,
    output logic                    r_almost_empty
`endif
);

    localparam int PTR_W = ptr_width(ADDRESS_SIZE);

    if (!depth_matches(MEMORY_DEPTH, ADDRESS_SIZE)) begin : g_bad_depth
        $error("r_clk_module: MEMORY_DEPTH must equal 2**ADDRESS_SIZE");
    end

    logic [PTR_W-1:0] r_bin;
    logic [PTR_W-1:0] r_bnext;
    logic [PTR_W-1:0] r_gnext;
    logic [PTR_W-1:0] rq2_wptr;
    logic             rd_accept;
    logic             addr_msb_q;
    logic             addr_msb_next;
    logic             empty_next;
    logic             r_rst_n;

    assign r_rst_n = ~r_rst;

    gray_to_binary #(.SIZE(PTR_W)) u_r_g2b (
        .gray (r_ptr),
        .bin  (r_bin)
    );

    assign rd_accept = r_en & ~r_empty;
    assign r_bnext   = r_bin + PTR_W'(rd_accept);

    binary_to_gray #(.SIZE(PTR_W)) u_r_b2g (
        .bin  (r_bnext),
        .gray (r_gnext)
    );

    d_ff_async #(.SIZE(PTR_W)) u_r_ptr_ff (
        .clk (r_clk),
        .rst (r_rst),
        .d   (r_gnext),
        .q   (r_ptr)
    );

    // The msb is kept in its own register so the address mapping matches the write side.
    assign addr_msb_next = addr_msb(32'(r_gnext), ADDRESS_SIZE);

    d_ff_async #(.SIZE(1)) u_addr_msb_ff (
        .clk (r_clk),
        .rst (r_rst),
        .d   (addr_msb_next),
        .q   (addr_msb_q)
    );

    assign r_addr = {addr_msb_q, r_ptr[ADDRESS_SIZE-2:0]};

    two_ff_synchronizer #(.SIZE(PTR_W)) u_wptr_sync (
        .clk   (r_clk),
        .rst_n (r_rst_n),
        .d     (w_ptr),
        .q     (rq2_wptr)
    );

    assign empty_next = (r_gnext == rq2_wptr);

    d_ff_async #(.SIZE(1), .RESET_VALUE(1'b1)) u_empty_ff (
        .clk (r_clk),
        .rst (r_rst),
        .d   (empty_next),
        .q   (r_empty)
    );

`ifdef R_LEVEL_EN
    r_level_calc #(
        .ADDRESS_SIZE        (ADDRESS_SIZE),
        .ALMOST_EMPTY_THRESH (ALMOST_EMPTY_THRESH)
    ) u_level (
        .clk            (r_clk),
        .rst            (r_rst),
        .w_gray_sync    (rq2_wptr),
        .r_bnext        (r_bnext),
        .r_level        (r_level),
        .r_almost_empty (r_almost_empty)
    );
`endif

endmodule

// File: tb/tb_r_clk_module.sv
// Directed testbench for r_clk_module (ADDRESS_SIZE=4); level checks run when R_LEVEL_EN is defined.
module tb_r_clk_module;

    logic       r_clk = 1'b0;
    logic       r_rst;
    logic       r_en;
    logic [4:0] w_ptr;
    logic [4:0] r_ptr;
    logic [3:0] r_addr;
    logic       r_empty;
`ifdef R_LEVEL_EN
    logic [4:0] r_level;
    logic       r_almost_empty;
`endif

    int checks = 0;
    int errors = 0;

    typedef struct {
        string      name;
        logic       rst;
        logic       ren;
        logic [4:0] wptr;
        logic [4:0] expPtr;
        logic [3:0] expAddr;
        logic       expEmpty;
    } vec_t;

    vec_t vecs[$];

    always #5 r_clk = ~r_clk;

    r_clk_module #(
        .MEMORY_DEPTH        (16),
        .ADDRESS_SIZE        (4),
        .ALMOST_EMPTY_THRESH (2)
    ) dut (
        .r_clk          (r_clk),
        .r_rst          (r_rst),
        .r_en           (r_en),
        .w_ptr          (w_ptr),
        .r_ptr          (r_ptr),
        .r_addr         (r_addr),
        .r_empty        (r_empty)
`ifdef R_LEVEL_EN
        ,
        .r_level        (r_level),
        .r_almost_empty (r_almost_empty)
`endif
    );

    function automatic logic [4:0] toGray(input logic [4:0] b);
        return b ^ (b >> 1);
    endfunction

    function automatic void addVec(input string name, input logic rst, input logic ren,
                                   input logic [4:0] wptr, input logic [4:0] expPtr,
                                   input logic [3:0] expAddr, input logic expEmpty);
        vec_t v;
        v.name = name; v.rst = rst; v.ren = ren; v.wptr = wptr;
        v.expPtr = expPtr; v.expAddr = expAddr; v.expEmpty = expEmpty;
        vecs.push_back(v);
    endfunction

    task automatic tick();
        @(posedge r_clk);
        #1;
    endtask

    task automatic applyStimulus(input logic rst, input logic ren, input logic [4:0] wptr);
        r_rst = rst;
        r_en  = ren;
        w_ptr = wptr;
        tick();
    endtask

    task automatic checkValue(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
        end
    endtask

    task automatic checkOutput(input string name, input logic [4:0] expPtr,
                               input logic [3:0] expAddr, input logic expEmpty);
        checkValue({name, ".r_ptr"},   32'(r_ptr),   32'(expPtr));
        checkValue({name, ".r_addr"},  32'(r_addr),  32'(expAddr));
        checkValue({name, ".r_empty"}, 32'(r_empty), 32'(expEmpty));
    endtask

    task automatic checkLevel(input string name, input int expLevel, input logic expAlmost);
`ifdef R_LEVEL_EN
        checkValue({name, ".r_level"},        32'(r_level),        32'(expLevel));
        checkValue({name, ".r_almost_empty"}, 32'(r_almost_empty), 32'(expAlmost));
`else
        if (name.len() < 0) $display("[TB] %s %0d %0b", name, expLevel, expAlmost);
`endif
    endtask

    // Drains count entries starting from binary read count startCount.
    task automatic drain(input string name, input int startCount, input int count, input logic [4:0] wptr);
        for (int k = 1; k <= count; k++) begin
            logic [4:0] kb;
            logic [4:0] g;
            kb = 5'(startCount + k);
            g  = toGray(kb);
            applyStimulus(1'b0, 1'b1, wptr);
            checkOutput($sformatf("%s_%0d", name, k), g, {kb[3], g[2:0]}, (k == count));
        end
    endtask

    initial begin
        r_rst = 1'b1;
        r_en  = 1'b0;
        w_ptr = 5'b00000;
        #2;

        addVec("rst_hold0", 1, 0, 5'b00011, 5'b00000, 4'd0, 1);
        addVec("rst_hold1", 1, 0, 5'b00011, 5'b00000, 4'd0, 1);
        addVec("rst_hold2", 1, 0, 5'b00011, 5'b00000, 4'd0, 1);
        addVec("rel_e1",    0, 0, 5'b00011, 5'b00000, 4'd0, 1);
        addVec("rel_e2",    0, 0, 5'b00011, 5'b00000, 4'd0, 1);
        addVec("rel_e3",    0, 0, 5'b00011, 5'b00000, 4'd0, 0);
        addVec("read1",     0, 1, 5'b00011, 5'b00001, 4'd1, 0);
        addVec("read_last", 0, 1, 5'b00011, 5'b00011, 4'd3, 1);
        for (int i = 0; i < 5; i++)
            addVec($sformatf("ren_empty%0d", i), 0, 1, 5'b00011, 5'b00011, 4'd3, 1);
        addVec("rst2",      1, 0, 5'b00000, 5'b00000, 4'd0, 1);
        addVec("w1_e1",     0, 0, 5'b00001, 5'b00000, 4'd0, 1);
        addVec("w1_e2",     0, 0, 5'b00001, 5'b00000, 4'd0, 1);
        addVec("w1_e3",     0, 0, 5'b00001, 5'b00000, 4'd0, 0);
        addVec("pulse",     0, 1, 5'b00001, 5'b00001, 4'd1, 1);
        addVec("idle",      0, 0, 5'b00001, 5'b00001, 4'd1, 1);

        foreach (vecs[i]) begin
            applyStimulus(vecs[i].rst, vecs[i].ren, vecs[i].wptr);
            checkOutput(vecs[i].name, vecs[i].expPtr, vecs[i].expAddr, vecs[i].expEmpty);
        end

        // Two full fill-and-drain rounds exercise address and pointer wrap.
        applyStimulus(1'b1, 1'b0, 5'b00000);
        applyStimulus(1'b0, 1'b0, 5'b11000);
        applyStimulus(1'b0, 1'b0, 5'b11000);
        applyStimulus(1'b0, 1'b0, 5'b11000);
        checkOutput("fill1", 5'b00000, 4'd0, 1'b0);
        drain("drain1", 0, 16, 5'b11000);
        checkOutput("drain1_end", 5'b11000, 4'd0, 1'b1);
        applyStimulus(1'b0, 1'b0, 5'b00000);
        applyStimulus(1'b0, 1'b0, 5'b00000);
        checkOutput("fill2_e2", 5'b11000, 4'd0, 1'b1);
        applyStimulus(1'b0, 1'b0, 5'b00000);
        checkOutput("fill2_e3", 5'b11000, 4'd0, 1'b0);
        drain("drain2", 16, 16, 5'b00000);
        checkOutput("drain2_end", 5'b00000, 4'd0, 1'b1);

        // Asynchronous reset between edges after seven reads.
        applyStimulus(1'b1, 1'b0, 5'b00000);
        checkLevel("lvl_rst", 0, 1'b1);
        applyStimulus(1'b0, 1'b0, 5'b01111);
        applyStimulus(1'b0, 1'b0, 5'b01111);
        applyStimulus(1'b0, 1'b0, 5'b01111);
        checkOutput("w10_e3", 5'b00000, 4'd0, 1'b0);
        checkLevel("lvl10", 10, 1'b0);
        for (int j = 1; j <= 7; j++) begin
            applyStimulus(1'b0, 1'b1, 5'b01111);
            checkLevel($sformatf("lvl_read%0d", j), 10 - j, (10 - j) <= 2);
        end
        checkOutput("read7", 5'b00100, 4'd4, 1'b0);
        r_en = 1'b0;
        #2;
        r_rst = 1'b1;
        #1;
        checkOutput("async_rst", 5'b00000, 4'd0, 1'b1);
        checkLevel("async_rst_lvl", 0, 1'b1);
        r_rst = 1'b0;
        applyStimulus(1'b0, 1'b0, 5'b01111);
        applyStimulus(1'b0, 1'b0, 5'b01111);
        checkOutput("rerel_e2", 5'b00000, 4'd0, 1'b1);
        applyStimulus(1'b0, 1'b0, 5'b01111);
        checkOutput("rerel_e3", 5'b00000, 4'd0, 1'b0);
        for (int j = 1; j <= 8; j++) begin
            applyStimulus(1'b0, 1'b1, 5'b01111);
        end
        checkOutput("read8", 5'b01100, 4'd12, 1'b0);
        checkLevel("lvl2", 2, 1'b1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
